// File: rtl/goomba_sprite_if.sv
// goomba_sprite_if: pixel-scan, control and sprite-ROM signals of one Goomba sprite controller
interface goomba_sprite_if;
   logic        frame_tick;
   logic        spawn;
   logic        stomp;
   logic [9:0]  goomba_x;
   logic [9:0]  goomba_y;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic [11:0] rom_color;
   logic [8:0]  read_address;
   logic [1:0]  frame_sel;
   logic [1:0]  state;
   logic        pixel_on;
   logic [11:0] pixel_color;
   modport master (
      output frame_tick, spawn, stomp, goomba_x, goomba_y, draw_x, draw_y, rom_color,
      input  read_address, frame_sel, state, pixel_on, pixel_color
   );
   modport slave (
      input  frame_tick, spawn, stomp, goomba_x, goomba_y, draw_x, draw_y, rom_color,
      output read_address, frame_sel, state, pixel_on, pixel_color
   );
endinterface

// File: rtl/goomba_sprite_ctrl.sv
// goomba_sprite_ctrl: Goomba lifecycle FSM, walk animation, hit test and 2-stage sprite pixel pipeline
module goomba_sprite_ctrl #(
   parameter int          SPRITE_W     = 20,
   parameter int          SPRITE_H     = 22,
   parameter int          ANIM_TICKS   = 8,
   parameter int          SQUASH_TICKS = 30,
   parameter logic [11:0] TRANSPARENT  = 12'h808
) (
   input logic             i_clk,
   input logic             i_rst,
   goomba_sprite_if.slave  bus
);
   localparam int AW = $clog2(ANIM_TICKS + 1);
   localparam int SW = $clog2(SQUASH_TICKS + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, SQUASH = 2'd2} state_t;
   state_t        r_state, w_state;
   logic [1:0]    r_frame_sel, w_frame_sel;
   logic [AW-1:0] r_anim_cnt, w_anim_cnt;
   logic [SW-1:0] r_sq_cnt, w_sq_cnt;
   logic [8:0]    r_addr, w_addr;
   logic          r_hit, w_hit;
   logic          r_pixel_on, w_opaque;
   logic [11:0]   r_pixel_color;
   logic [10:0]   w_dx, w_dy;
   logic          w_anim_wrap;
   assign w_anim_wrap = r_anim_cnt == AW'(ANIM_TICKS - 1);
   always_comb begin
      w_state     = r_state;
      w_frame_sel = r_frame_sel;
      w_anim_cnt  = r_anim_cnt;
      w_sq_cnt    = r_sq_cnt;
      case (r_state)
         IDLE: if (bus.spawn) begin
            w_state     = WALK;
            w_anim_cnt  = '0;
            w_frame_sel = 2'd0;
         end
         WALK: if (bus.stomp) begin
            w_state     = SQUASH;
            w_sq_cnt    = '0;
            w_frame_sel = 2'd2;
         end else if (bus.frame_tick) begin
            w_anim_cnt  = w_anim_wrap ? '0 : r_anim_cnt + 1'b1;
            w_frame_sel = w_anim_wrap ? {1'b0, ~r_frame_sel[0]} : r_frame_sel;
         end
         SQUASH: if (bus.frame_tick) begin
            w_state  = (r_sq_cnt == SW'(SQUASH_TICKS - 1)) ? IDLE : SQUASH;
            w_sq_cnt = (r_sq_cnt == SW'(SQUASH_TICKS - 1)) ? '0 : r_sq_cnt + 1'b1;
         end
         default: w_state = IDLE;
      endcase
   end
   // 11-bit arithmetic keeps boxes that straddle x/y = 1023 from wrapping onto low coordinates
   assign w_dx     = {1'b0, bus.draw_x} - {1'b0, bus.goomba_x};
   assign w_dy     = {1'b0, bus.draw_y} - {1'b0, bus.goomba_y};
   assign w_hit    = (r_state != IDLE)
                   && (bus.draw_x >= bus.goomba_x) && ({1'b0, bus.draw_x} < {1'b0, bus.goomba_x} + 11'(SPRITE_W))
                   && (bus.draw_y >= bus.goomba_y) && ({1'b0, bus.draw_y} < {1'b0, bus.goomba_y} + 11'(SPRITE_H));
   assign w_addr   = w_hit ? 9'(w_dy * 11'(SPRITE_W) + w_dx) : '0;
   assign w_opaque = r_hit && (bus.rom_color != TRANSPARENT);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_frame_sel   <= 2'd0;
         r_anim_cnt    <= '0;
         r_sq_cnt      <= '0;
         r_addr        <= '0;
         r_hit         <= 1'b0;
         r_pixel_on    <= 1'b0;
         r_pixel_color <= '0;
      end else begin
         r_state       <= w_state;
         r_frame_sel   <= w_frame_sel;
         r_anim_cnt    <= w_anim_cnt;
         r_sq_cnt      <= w_sq_cnt;
         r_addr        <= w_addr;
         r_hit         <= w_hit;
         r_pixel_on    <= w_opaque;
         r_pixel_color <= w_opaque ? bus.rom_color : 12'h000;
      end
   end
   assign bus.read_address = r_addr;
   assign bus.frame_sel    = r_frame_sel;
   assign bus.state        = r_state;
   assign bus.pixel_on     = r_pixel_on;
   assign bus.pixel_color  = r_pixel_color;
endmodule

// File: tb/tb_goomba_sprite_ctrl.sv
// tb_goomba_sprite_ctrl: directed plus randomized checks against a tick-counting behavioural model
module tb_goomba_sprite_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_force = 1'b0;
   logic [11:0] rom_val = 12'h000;
   int          n_checks = 0;
   int          n_errors = 0;
   int          m_state, m_fs, m_walk_ticks, m_sq_ticks, m_addr, m_hit, m_pon, m_pcol;
   goomba_sprite_if gif();
   goomba_sprite_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(gif.slave));
   always #5 clk = ~clk;
   function automatic logic [11:0] rom_fn(int sel, int a);
      return (a % 7 == sel) ? 12'h808 : 12'((a * 13 + sel * 401 + 1) & 12'hFFF);
   endfunction
   assign gif.rom_color = rom_force ? rom_val : rom_fn(int'(gif.frame_sel), int'(gif.read_address));
   task automatic check(string tag, int obs, int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Reference: walk frame = (ticks since spawn / 8) mod 2; squash lasts 30 ticks
   task automatic model_edge();
      int romv, dx, dy, hit;
      if (rst) begin
         m_state = 0; m_fs = 0; m_walk_ticks = 0; m_sq_ticks = 0;
         m_addr = 0; m_hit = 0; m_pon = 0; m_pcol = 0;
         return;
      end
      romv   = rom_force ? int'(rom_val) : int'(rom_fn(m_fs, m_addr));
      m_pon  = (m_hit != 0 && romv != 'h808) ? 1 : 0;
      m_pcol = m_pon ? romv : 0;
      dx     = int'(gif.draw_x) - int'(gif.goomba_x);
      dy     = int'(gif.draw_y) - int'(gif.goomba_y);
      hit    = (m_state != 0 && dx >= 0 && dx < 20 && dy >= 0 && dy < 22) ? 1 : 0;
      m_hit  = hit;
      m_addr = hit ? dy * 20 + dx : 0;
      if (m_state == 0 && gif.spawn) begin
         m_state = 1; m_walk_ticks = 0; m_fs = 0;
      end else if (m_state == 1 && gif.stomp) begin
         m_state = 2; m_sq_ticks = 0; m_fs = 2;
      end else if (m_state == 1 && gif.frame_tick) begin
         m_walk_ticks++;
         m_fs = (m_walk_ticks / 8) % 2;
      end else if (m_state == 2 && gif.frame_tick) begin
         m_sq_ticks++;
         if (m_sq_ticks == 30) m_state = 0;
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("state", int'(gif.state), m_state);
      check("frame_sel", int'(gif.frame_sel), m_fs);
      check("read_address", int'(gif.read_address), m_addr);
      check("pixel_on", int'(gif.pixel_on), m_pon);
      check("pixel_color", int'(gif.pixel_color), m_pcol);
   endtask
   initial begin
      gif.frame_tick = 0; gif.spawn = 0; gif.stomp = 0;
      gif.goomba_x = 10'd100; gif.goomba_y = 10'd50;
      gif.draw_x = 10'd103; gif.draw_y = 10'd52;
      cyc(); cyc();
      rst = 0;
      cyc(); cyc();
      check("idle_state", int'(gif.state), 0);
      check("idle_pixel_on", int'(gif.pixel_on), 0);
      check("idle_addr", int'(gif.read_address), 0);
      gif.spawn = 1; cyc(); gif.spawn = 0;
      check("spawn_state", int'(gif.state), 1);
      rom_force = 1; rom_val = 12'hE51;
      cyc();
      check("addr_43", int'(gif.read_address), 43);
      cyc();
      check("opaque_on", int'(gif.pixel_on), 1);
      check("opaque_color", int'(gif.pixel_color), 'hE51);
      rom_val = 12'h808;
      cyc();
      check("transparent_off", int'(gif.pixel_on), 0);
      rom_val = 12'hE51;
      gif.draw_x = 10'd119; gif.draw_y = 10'd71; cyc();
      check("addr_439", int'(gif.read_address), 439);
      gif.draw_x = 10'd120; gif.draw_y = 10'd50; cyc();
      check("miss_right", int'(gif.read_address), 0);
      gif.draw_x = 10'd100; gif.draw_y = 10'd72; cyc();
      check("miss_below", int'(gif.read_address), 0);
      gif.goomba_x = 10'd1015; gif.draw_x = 10'd5; gif.draw_y = 10'd52; cyc(); cyc();
      check("no_wrap", int'(gif.pixel_on), 0);
      gif.goomba_x = 10'd100; gif.draw_x = 10'd103;
      for (int i = 1; i <= 16; i++) begin
         gif.frame_tick = 1; cyc(); gif.frame_tick = 0; cyc();
         if (i == 7) check("tick7_frame", int'(gif.frame_sel), 0);
         if (i == 8) check("tick8_frame", int'(gif.frame_sel), 1);
         if (i == 16) check("tick16_frame", int'(gif.frame_sel), 0);
      end
      gif.stomp = 1; cyc(); gif.stomp = 0;
      check("stomp_state", int'(gif.state), 2);
      check("stomp_frame", int'(gif.frame_sel), 2);
      for (int i = 1; i <= 30; i++) begin
         gif.frame_tick = 1; cyc(); gif.frame_tick = 0;
         if (i == 29) check("squash_hold", int'(gif.state), 2);
      end
      check("squash_done", int'(gif.state), 0);
      cyc(); cyc();
      check("idle_no_pixel", int'(gif.pixel_on), 0);
      gif.stomp = 1; cyc(); gif.stomp = 0;
      check("stomp_in_idle", int'(gif.state), 0);
      gif.spawn = 1; cyc();
      gif.stomp = 1; cyc(); gif.spawn = 0; gif.stomp = 0;
      check("spawn_stomp", int'(gif.state), 2);
      rst = 1; gif.frame_tick = 1; cyc(); rst = 0; gif.frame_tick = 0;
      check("rst_state", int'(gif.state), 0);
      check("rst_frame", int'(gif.frame_sel), 0);
      rom_force = 0;
      for (int i = 0; i < 4000; i++) begin
         rst            = ($urandom_range(0, 499) == 0);
         gif.spawn      = ($urandom_range(0, 19) == 0);
         gif.stomp      = ($urandom_range(0, 59) == 0);
         gif.frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) begin
            gif.goomba_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 1023));
            gif.goomba_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 9) < 8) begin
            gif.draw_x = 10'(int'(gif.goomba_x) + int'($urandom_range(0, 26)) - 3);
            gif.draw_y = 10'(int'(gif.goomba_y) + int'($urandom_range(0, 28)) - 3);
         end else begin
            gif.draw_x = 10'($urandom_range(0, 1023));
            gif.draw_y = 10'($urandom_range(0, 1023));
         end
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/goomba_sprite_ctrl.md
# goomba_sprite_ctrl

Sequences one Goomba enemy's sprite ROMs: per-pixel hit testing, ROM read-address generation, walk-animation frame selection, and a spawn/walk/squash lifecycle FSM. It sits between the VGA pixel scan (draw_x/draw_y) and the Goomba sprite ROMs (walk frame 1, walk frame 2, squashed; each 20x22 entries, 9-bit address, 12-bit palette color, combinational read). It emits a pipelined pixel_on/pixel_color pair to the color mapper.

## Interface
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 22, sprite height in pixels (SPRITE_W*SPRITE_H ≤ 512)
- ANIM_TICKS, 8, frame_tick pulses per walk-frame toggle
- SQUASH_TICKS, 30, frame_tick pulses the squashed sprite stays visible
- TRANSPARENT, 12'h808, palette color treated as transparent

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- spawn  in  1  one-cycle request to activate the Goomba
- stomp  in  1  one-cycle request: player landed on the Goomba
- goomba_x, goomba_y  in  10 each  top-left sprite position on screen
- draw_x, draw_y  in  10 each  current scan pixel
- rom_color  in  12  color from the ROM selected by frame_sel at read_address
- read_address  out  9  ROM address, shared by all three ROMs
- frame_sel  out  2  0 = walk 1, 1 = walk 2, 2 = squashed
- state  out  2  0 = IDLE, 1 = WALK, 2 = SQUASH
- pixel_on  out  1  Goomba owns this pixel (opaque and in-box)
- pixel_color  out  12  color for pixel_on

## Operation
- FSM IDLE → WALK on spawn. Entry clears anim_cnt and sets frame_sel=0.
- WALK → SQUASH on stomp. Entry clears sq_cnt and sets frame_sel=2.
- SQUASH → IDLE on the frame_tick where sq_cnt == SQUASH_TICKS-1.
- spawn is ignored outside IDLE. stomp is ignored outside WALK.
- In WALK, if spawn and stomp arrive together, stomp takes effect. In IDLE, spawn takes effect.
- Animation in WALK:
  - anim_cnt increments on each frame_tick.
  - On the tick where anim_cnt == ANIM_TICKS-1, anim_cnt wraps to 0 and frame_sel toggles between 0 and 1.
  - frame_sel changes only on frame_tick cycles or on FSM transitions, so no tearing within a frame.
- sq_cnt increments on each frame_tick in SQUASH. frame_tick in IDLE has no effect.
- Hit test:
  - Condition: draw_x ≥ goomba_x, draw_x < goomba_x+SPRITE_W, draw_y ≥ goomba_y, draw_y < goomba_y+SPRITE_H.
  - Computed in 11 bits so positions near 1023 do not wrap.
  - Hit is forced to 0 in IDLE.
- Address: dy*SPRITE_W + dx, where dx = draw_x-goomba_x and dy = draw_y-goomba_y. Maximum value is 439. On a miss, read_address = 0.
- Output stage:
  - pixel_on = registered hit AND rom_color != TRANSPARENT.
  - pixel_color = rom_color when pixel_on, else 0.

## Timing
- Reset (synchronous): state=IDLE, frame_sel=0, read_address=0, anim_cnt=sq_cnt=0, hit pipe=0, pixel_on=0, pixel_color=0.
- Stage 1: read_address and hit_q are registered from draw_x/draw_y at cycle N and valid at N+1. The ROM returns rom_color combinationally in cycle N+1.
- Stage 2: pixel_on and pixel_color are registered at the end of N+1 and valid at N+2. Total latency is 2 cycles. The color mapper delays draw coordinates to match.
- FSM transitions and counter updates take effect on the clock edge where the request is sampled; state and frame_sel are valid the next cycle.
- An FSM transition into IDLE zeroes hit for new pixels. Up to 2 already-pipelined pixels may still assert pixel_on. This is acceptable.
- Reset asserted mid-operation overrides everything, including a simultaneous spawn, stomp or frame_tick.

## Test plan
- Reset held 2 cycles, then released with spawn=0 → state=0, pixel_on=0 for any draw_x/draw_y; read_address=0.
- Spawn, goomba=(100,50), draw=(103,52) → read_address=43 one cycle later. With rom_color=12'hE51, pixel_on=1 and pixel_color=E51 two cycles after draw. With rom_color=12'h808, pixel_on=0.
- Edge check: draw=(119,71) → hit, address 439. draw=(120,50) → miss. draw=(100,72) → miss. goomba_x=1015, draw_x=5 → miss (no wrap).
- WALK with 8 frame_ticks → frame_sel goes 0→1 on tick 8, back to 0 on tick 16. Ticks 1–7 leave it unchanged.
- Stomp in WALK → state=2, frame_sel=2 next cycle. After 30 frame_ticks → state=0, pixel_on=0. A stomp in IDLE has no effect.
- Simultaneous spawn+stomp in WALK → SQUASH. Reset asserted in SQUASH with frame_tick high → IDLE, all counters 0.
